// File: rtl/sb_rx_decoder_pkg.sv
// ---------------------------------------------------------------------------
// sb_rx_decoder_pkg
// Shared sideband (SB) codex definitions used by the sideband receive decoder:
//   - 64-bit clock-pattern constant
//   - field bit positions inside a received sideband word
//   - opcode / msgcode constants
//   - packed decoded-message record and helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package sb_rx_decoder_pkg;

    // A word made of alternating ones and zeros marks clock-pattern training.
    localparam logic [63:0] SB_CLOCK_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    // Field positions inside a sideband header word.
    localparam int SB_OPCODE_LSB  = 0;
    localparam int SB_MSGCODE_LSB = 14;
    localparam int SB_MSGINFO_LSB = 24;
    localparam int SB_SUBCODE_LSB = 48;
    localparam int SB_CP_BIT      = 62;
    localparam int SB_DP_BIT      = 63;

    typedef enum logic [4:0] {
        SB_OPC_MSG_NO_DATA   = 5'h12,
        SB_OPC_MSG_WITH_DATA = 5'h1B
    } sb_opcode_e;

    localparam logic [7:0] SB_MSGCODE_REQ  = 8'h91;
    localparam logic [7:0] SB_MSGCODE_RESP = 8'h92;

    // Decoded message as stored in the FIFO, most significant field first.
    typedef struct packed {
        logic [7:0]  subcode;
        logic [15:0] info;
        logic [7:0]  code;
        logic [4:0]  opcode;
    } sb_msg_t;

    function automatic sb_msg_t sbExtractMsg(input logic [63:0] word);
        sb_msg_t msg;
        msg.opcode  = word[SB_OPCODE_LSB  +: 5];
        msg.code    = word[SB_MSGCODE_LSB +: 8];
        msg.info    = word[SB_MSGINFO_LSB +: 16];
        msg.subcode = word[SB_SUBCODE_LSB +: 8];
        return msg;
    endfunction

    // Control parity covers bits [61:0]; data parity must be clear when the
    // word carries no data payload.
    function automatic logic sbParityOk(input logic [63:0] word);
        logic cpOk;
        logic dpOk;
        cpOk = (word[SB_CP_BIT] == ^word[61:0]);
        dpOk = !((word[SB_OPCODE_LSB +: 5] == SB_OPC_MSG_NO_DATA) && word[SB_DP_BIT]);
        return cpOk && dpOk;
    endfunction

endpackage

// File: rtl/sb_rx_decoder_fifo.sv
// ---------------------------------------------------------------------------
// sb_msg_fifo
// Synchronous FIFO for decoded sideband messages.
// Ports:
//   clk_100MHz, reset (async, active-high)
//   flush    : synchronous clear, wins over push/pop in the same cycle
//   push     : write pushData (ignored when full unless a pop happens too)
//   pop      : drop head entry (ignored when empty)
//   popData  : head entry, read combinationally from storage
//   full / empty status
// ---------------------------------------------------------------------------
module sb_msg_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, so throughput is not lost at the boundary.
    assign doPop  = pop && !flush && !empty;
    assign doPush = push && !flush && (!full || doPop);

    assign popData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk_100MHz) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/sb_rx_decoder.sv
// ---------------------------------------------------------------------------
// sb_rx_decoder
// Sideband receive decoder: classifies incoming 64-bit sideband words as
// clock pattern or message, optionally checks parity, and buffers decoded
// message fields in a FIFO for a downstream consumer.
// Optional feature macro: SB_RX_PARITY_CHECK_EN (parity checking and error
// counting; when undefined every non-pattern word is enqueued).
// Ports:
//   clk_100MHz, reset (async, active-high)
//   rx_word_i / rx_valid_i : received word and its one-cycle strobe
//   flush_i                : clears FIFO, pattern counter, overflow flag
//   msg_ready_i            : consumer accepts head entry
//   msg_valid_o, msg_opcode_o, msg_code_o, msg_info_o, msg_subcode_o : head
//   pattern_det_o          : PAT_COUNT consecutive pattern words seen
//   parity_err_o / err_cnt_o : parity failure pulse / saturating count
//   overflow_o             : sticky, a message was dropped on a full FIFO
// ---------------------------------------------------------------------------
module sb_rx_decoder
    import sb_rx_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PAT_COUNT  = 2
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [63:0] rx_word_i,
    input  logic        rx_valid_i,
    input  logic        flush_i,
    input  logic        msg_ready_i,
    output logic        msg_valid_o,
    output logic [4:0]  msg_opcode_o,
    output logic [7:0]  msg_code_o,
    output logic [15:0] msg_info_o,
    output logic [7:0]  msg_subcode_o,
    output logic        pattern_det_o,
    output logic        parity_err_o,
    output logic [7:0]  err_cnt_o,
    output logic        overflow_o
);

    localparam int              PCW     = $clog2(PAT_COUNT + 1);
    localparam logic [PCW-1:0]  PAT_MAX = PCW'(PAT_COUNT);

    logic           isPattern;
    logic           parityOk;
    logic           wordAccepted;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           doPop;
    sb_msg_t        inMsg;
    sb_msg_t        headMsg;
    logic [PCW-1:0] patCount;
    logic           overflowReg;

    assign isPattern    = (rx_word_i == SB_CLOCK_PATTERN);
    assign inMsg        = sbExtractMsg(rx_word_i);
    assign wordAccepted = rx_valid_i && !isPattern && parityOk;
    assign doPop        = !fifoEmpty && msg_ready_i;

`ifdef SB_RX_PARITY_CHECK_EN
    logic       parityFail;
    logic       parityErrReg;
    logic [7:0] errCntReg;

    // Pattern words are exempt: the alternating pattern never satisfies the
    // header parity rule.
    assign parityOk   = sbParityOk(rx_word_i);
    assign parityFail = rx_valid_i && !isPattern && !parityOk;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            parityErrReg <= 1'b0;
            errCntReg    <= 8'h00;
        end else begin
            parityErrReg <= parityFail;
            if (parityFail && (errCntReg != 8'hFF)) errCntReg <= errCntReg + 8'd1;
        end
    end

    assign parity_err_o = parityErrReg;
    assign err_cnt_o    = errCntReg;
`else
    assign parityOk     = 1'b1;
    assign parity_err_o = 1'b0;
    assign err_cnt_o    = 8'h00;
`endif

    // Consecutive-pattern counter: any valid non-pattern word breaks the run.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            patCount <= '0;
        end else if (flush_i) begin
            patCount <= '0;
        end else if (rx_valid_i) begin
            if (!isPattern)             patCount <= '0;
            else if (patCount != PAT_MAX) patCount <= patCount + PCW'(1);
        end
    end

    assign pattern_det_o = (patCount == PAT_MAX);

    // Overflow only when the word truly cannot enter: full and no pop.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            overflowReg <= 1'b0;
        end else if (flush_i) begin
            overflowReg <= 1'b0;
        end else if (wordAccepted && fifoFull && !doPop) begin
            overflowReg <= 1'b1;
        end
    end

    assign overflow_o = overflowReg;

    sb_msg_fifo #(
        .WIDTH ($bits(sb_msg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_msgFifo (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .flush      (flush_i),
        .push       (wordAccepted),
        .pushData   (inMsg),
        .pop        (doPop),
        .popData    (headMsg),
        .full       (fifoFull),
        .empty      (fifoEmpty)
    );

    // Fields read as zero whenever nothing is queued, so reset and flush
    // leave every output at 0 without resetting the storage array.
    assign msg_valid_o   = !fifoEmpty;
    assign msg_opcode_o  = fifoEmpty ? 5'h00  : headMsg.opcode;
    assign msg_code_o    = fifoEmpty ? 8'h00  : headMsg.code;
    assign msg_info_o    = fifoEmpty ? 16'h0  : headMsg.info;
    assign msg_subcode_o = fifoEmpty ? 8'h00  : headMsg.subcode;

endmodule

// File: tb/tb_sb_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_sb_rx_decoder
// Self-checking bench for sb_rx_decoder (default parameters). Expectations
// adapt to the SB_RX_PARITY_CHECK_EN macro.
// ---------------------------------------------------------------------------
module tb_sb_rx_decoder;

    localparam int          DEPTH = 4;
    localparam int          PAT   = 2;
    localparam logic [63:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic [63:0] rx_word_i  = '0;
    logic        rx_valid_i = 1'b0;
    logic        flush_i    = 1'b0;
    logic        msg_ready_i = 1'b0;
    logic        msg_valid_o;
    logic [4:0]  msg_opcode_o;
    logic [7:0]  msg_code_o;
    logic [15:0] msg_info_o;
    logic [7:0]  msg_subcode_o;
    logic        pattern_det_o;
    logic        parity_err_o;
    logic [7:0]  err_cnt_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    sb_rx_decoder #(
        .FIFO_DEPTH (DEPTH),
        .PAT_COUNT  (PAT)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .rx_word_i     (rx_word_i),
        .rx_valid_i    (rx_valid_i),
        .flush_i       (flush_i),
        .msg_ready_i   (msg_ready_i),
        .msg_valid_o   (msg_valid_o),
        .msg_opcode_o  (msg_opcode_o),
        .msg_code_o    (msg_code_o),
        .msg_info_o    (msg_info_o),
        .msg_subcode_o (msg_subcode_o),
        .pattern_det_o (pattern_det_o),
        .parity_err_o  (parity_err_o),
        .err_cnt_o     (err_cnt_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Reference model: queue of decoded messages plus a few scalar counters.
    typedef struct {
        logic [4:0]  opcode;
        logic [7:0]  code;
        logic [15:0] info;
        logic [7:0]  subcode;
    } ref_msg_t;

    ref_msg_t modelQ[$];
    int       modelPat    = 0;
    bit       modelOvf    = 0;
    int       modelErr    = 0;
    bit       modelParErr = 0;

    typedef struct {
        logic [63:0] word;
        bit          valid;
        bit          flush;
        bit          ready;
        bit          expValid;
        logic [4:0]  expOpcode;
        logic [7:0]  expCode;
        bit          expPatDet;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [63:0] makeMsg(input logic [4:0] opc, input logic [7:0] code,
                                            input logic [15:0] info, input logic [7:0] sub);
        logic [63:0] w;
        w        = '0;
        w[4:0]   = opc;
        w[21:14] = code;
        w[39:24] = info;
        w[55:48] = sub;
        w[62]    = ^w[61:0];
        return w;
    endfunction

    function automatic bit wordGood(input logic [63:0] w);
`ifdef SB_RX_PARITY_CHECK_EN
        bit cpGood;
        bit dpGood;
        cpGood = (($countones(w[61:0]) % 2) == int'(w[62]));
        dpGood = !((w[4:0] == 5'h12) && w[63]);
        return cpGood && dpGood;
`else
        return (w != 64'd0) || (w == 64'd0);
`endif
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelPat    = 0;
        modelOvf    = 0;
        modelErr    = 0;
        modelParErr = 0;
    endtask

    task automatic modelStep(input logic [63:0] w, input bit valid, input bit flush, input bit ready);
        bit       isPat;
        bit       good;
        bit       popNow;
        ref_msg_t m;
        isPat       = valid && (w == PATTERN_WORD);
        good        = wordGood(w);
        modelParErr = valid && !isPat && !good;
        if (modelParErr && modelErr < 255) modelErr++;
        popNow = (modelQ.size() > 0) && ready;
        if (flush) begin
            modelQ.delete();
            modelPat = 0;
            modelOvf = 0;
        end else begin
            if (popNow) void'(modelQ.pop_front());
            if (valid && !isPat && good) begin
                m.opcode  = w[4:0];
                m.code    = w[21:14];
                m.info    = w[39:24];
                m.subcode = w[55:48];
                if (modelQ.size() < DEPTH) modelQ.push_back(m);
                else                       modelOvf = 1;
            end
            if (valid) modelPat = isPat ? ((modelPat + 1 > PAT) ? PAT : modelPat + 1) : 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        ref_msg_t head;
        head = '{default: '0};
        if (modelQ.size() > 0) head = modelQ[0];
        checkOutput({tag, "_valid"},   msg_valid_o,   64'(modelQ.size() > 0));
        checkOutput({tag, "_opcode"},  msg_opcode_o,  64'(head.opcode));
        checkOutput({tag, "_code"},    msg_code_o,    64'(head.code));
        checkOutput({tag, "_info"},    msg_info_o,    64'(head.info));
        checkOutput({tag, "_subcode"}, msg_subcode_o, 64'(head.subcode));
        checkOutput({tag, "_patdet"},  pattern_det_o, 64'(modelPat == PAT));
        checkOutput({tag, "_parerr"},  parity_err_o,  64'(modelParErr));
        checkOutput({tag, "_errcnt"},  err_cnt_o,     64'(modelErr));
        checkOutput({tag, "_ovf"},     overflow_o,    64'(modelOvf));
    endtask

    // Drives one cycle of inputs, steps the model across the edge and
    // compares everything #1 after the edge.
    task automatic applyStimulus(input logic [63:0] w, input bit valid, input bit flush,
                                 input bit ready, input string tag);
        rx_word_i   = w;
        rx_valid_i  = valid;
        flush_i     = flush;
        msg_ready_i = ready;
        modelStep(w, valid, flush, ready);
        @(posedge clk_100MHz);
        #1;
        rx_valid_i = 1'b0;
        flush_i    = 1'b0;
        checkModel(tag);
    endtask

    initial begin
        logic [63:0] msgA;
        logic [63:0] msgB;
        logic [63:0] w;
        logic [7:0]  c;

        msgA = makeMsg(5'h12, 8'h91, 16'h1234, 8'h00);
        msgB = makeMsg(5'h1B, 8'h22, 16'hBEEF, 8'h5A);

        vecs[0] = '{PATTERN_WORD, 1, 0, 0, 0, 5'h00, 8'h00, 0};
        vecs[1] = '{PATTERN_WORD, 1, 0, 0, 0, 5'h00, 8'h00, 1};
        vecs[2] = '{64'd0,        0, 0, 0, 0, 5'h00, 8'h00, 1};
        vecs[3] = '{msgA,         1, 0, 0, 1, 5'h12, 8'h91, 0};
        vecs[4] = '{64'd0,        0, 0, 0, 1, 5'h12, 8'h91, 0};
        vecs[5] = '{64'd0,        0, 0, 1, 0, 5'h00, 8'h00, 0};
        vecs[6] = '{PATTERN_WORD, 1, 0, 0, 0, 5'h00, 8'h00, 0};
        vecs[7] = '{msgB,         1, 0, 0, 1, 5'h1B, 8'h22, 0};
        vecs[8] = '{PATTERN_WORD, 1, 0, 1, 0, 5'h00, 8'h00, 0};
        vecs[9] = '{64'd0,        0, 0, 0, 0, 5'h00, 8'h00, 0};

        // Reset state
        modelReset();
        repeat (2) @(posedge clk_100MHz);
        #1;
        checkModel("reset");
        reset = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].word, vecs[i].valid, vecs[i].flush, vecs[i].ready, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_hand_valid", i),  msg_valid_o,   64'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_hand_opcode", i), msg_opcode_o,  64'(vecs[i].expOpcode));
            checkOutput($sformatf("vec%0d_hand_code", i),   msg_code_o,    64'(vecs[i].expCode));
            checkOutput($sformatf("vec%0d_hand_patdet", i), pattern_det_o, 64'(vecs[i].expPatDet));
        end

        // Overflow: five words into a depth-four FIFO, drain in order
        for (int i = 0; i < 5; i++) begin
            c = 8'(8'h10 + i);
            applyStimulus(makeMsg(5'h12, c, 16'h0, 8'h00), 1, 0, 0, "ovf_fill");
        end
        checkOutput("ovf_set", overflow_o, 64'd1);
        checkOutput("ovf_head0", msg_code_o, 64'h10);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(64'd0, 0, 0, 1, "ovf_drain");
            checkOutput($sformatf("ovf_head%0d", i), msg_code_o, 64'(8'h10 + i));
        end
        applyStimulus(64'd0, 0, 0, 1, "ovf_drain_last");
        checkOutput("ovf_drained", msg_valid_o, 64'd0);
        applyStimulus(msgA, 1, 0, 0, "ovf_refill");
        applyStimulus(64'd0, 0, 1, 0, "ovf_flush");
        checkOutput("flush_valid", msg_valid_o, 64'd0);
        checkOutput("flush_ovf", overflow_o, 64'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            c = 8'(8'h20 + i);
            applyStimulus(makeMsg(5'h12, c, 16'h0, 8'h00), 1, 0, 0, "full_fill");
        end
        applyStimulus(makeMsg(5'h12, 8'h24, 16'h0, 8'h00), 1, 0, 1, "full_pushpop");
        checkOutput("full_pushpop_ovf", overflow_o, 64'd0);
        checkOutput("full_pushpop_head", msg_code_o, 64'h21);
        applyStimulus(msgB, 1, 1, 1, "flush_priority");
        checkOutput("flush_priority_valid", msg_valid_o, 64'd0);

        // Parity: flipped control-parity bit, then bad data-parity bit
        w = msgA ^ (64'd1 << 62);
        applyStimulus(w, 1, 0, 0, "par_cp");
`ifdef SB_RX_PARITY_CHECK_EN
        checkOutput("par_cp_pulse", parity_err_o, 64'd1);
        checkOutput("par_cp_cnt", err_cnt_o, 64'd1);
        checkOutput("par_cp_dropped", msg_valid_o, 64'd0);
`else
        checkOutput("par_cp_enq", msg_valid_o, 64'd1);
        checkOutput("par_cp_cnt", err_cnt_o, 64'd0);
`endif
        applyStimulus(64'd0, 0, 0, 0, "par_idle");
        checkOutput("par_pulse_end", parity_err_o, 64'd0);
        w = msgA ^ (64'd1 << 63);
        applyStimulus(w, 1, 0, 0, "par_dp");
        applyStimulus(64'd0, 0, 1, 0, "par_flush");

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) applyStimulus(msgB, 1, 0, 0, "rst_fill");
        applyStimulus(PATTERN_WORD, 1, 0, 0, "rst_pat");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkModel("async_reset");
        @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
        checkModel("after_reset");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int  kind;
            bit  valid;
            bit  flush;
            bit  ready;
            kind  = $urandom_range(0, 3);
            valid = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            ready = $urandom_range(0, 1);
            case (kind)
                0: w = PATTERN_WORD;
                1: w = {$urandom, $urandom};
                default: begin
                    w = makeMsg(($urandom_range(0, 1) == 1) ? 5'h12 : 5'(5'h1B),
                                8'($urandom), 16'($urandom), 8'($urandom));
                    if (w[4:0] != 5'h12 && $urandom_range(0, 1) == 1) w[63] = 1'b1;
                end
            endcase
            applyStimulus(w, valid, flush, ready, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
